// File: rtl/xarb_wrr_lock_pkg.sv
// Shared types and helpers for the xarb arbiter family.
package xarb_wrr_lock_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned XARB_MAXN = 32;
  localparam int unsigned XARB_WBUS = 256;

  function automatic logic [7:0] weight_field(input logic [XARB_WBUS-1:0] w,
                                              input int unsigned idx,
                                              input int unsigned ww);
    return 8'(w >> (idx * ww)) & 8'((32'd1 << ww) - 32'd1);
  endfunction

  function automatic logic [4:0] onehot_idx(input logic [XARB_MAXN-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < XARB_MAXN; i++)
      if (oh[i]) idx |= 5'(i);
    return idx;
  endfunction

endpackage

// File: rtl/xarb_wrr_lock_if.sv
// Requester/arbiter bundle; master drives requests, slave is the arbiter.
interface xarb_wrr_lock_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned WW = 4
);
  localparam int unsigned IW = $clog2(N);

  logic              en;
  logic [N-1:0]      req;
  logic [N-1:0]      last;
  logic [N*WW-1:0]   weight;
  logic              ready;
  logic [N-1:0]      gnt;
  logic [IW-1:0]     gnt_id;
  logic              gnt_vld;
  logic              xfer;

  modport master (output en, req, last, weight, ready,
                  input  gnt, gnt_id, gnt_vld, xfer);
  modport slave  (input  en, req, last, weight, ready,
                  output gnt, gnt_id, gnt_vld, xfer);
endinterface

// File: rtl/xarb_wrr_lock_rr_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module xarb_rr_pick
  import xarb_wrr_lock_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          any
);
  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  always_comb begin
    for (int unsigned i = 0; i < N; i++)
      mask[i] = (i >= 32'(ptr));
    masked = req & mask;
    // nothing at/after ptr means the wrapped search is just the lowest set bit
    src    = (|masked) ? masked : req;
    win    = src & (~src + N'(1));
    win_id = IW'(onehot_idx(XARB_MAXN'(win)));
    any    = |req;
  end
endmodule

// File: rtl/xarb_wrr_lock.sv
// Weighted round-robin arbiter with packet lock and zero-bubble handoff.
module xarb_wrr_lock
  import xarb_wrr_lock_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned WW = 4
) (
  input  logic           clk,
  input  logic           rstn,
  xarb_wrr_lock_if.slave bus
);
  localparam int unsigned IW = $clog2(N);

  state_t        state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q, ptr_q, ptr_nxt, pick_ptr, pick_id;
  logic [WW-1:0] credit_q, credit_ld;
  logic          inpkt_q;
  logic          cur_req, cur_last, xfer_c, tend, rel, can_grant, pick_any;
  logic [N-1:0]  pick_win;

  xarb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .win    (pick_win),
    .win_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    cur_req   = bus.req[gnt_id_q];
    cur_last  = bus.last[gnt_id_q];
    xfer_c    = (state_q == BUSY) & cur_req & bus.ready;
    tend      = xfer_c & cur_last;
    rel       = (state_q == BUSY) &
                ((tend & (credit_q == WW'(1))) |
                 (~inpkt_q & ~xfer_c & (~cur_req | ~bus.en)));
    ptr_nxt   = (gnt_id_q == IW'(N-1)) ? '0 : gnt_id_q + 1'b1;
    // on release the search starts past the old winner in the same cycle
    pick_ptr  = rel ? ptr_nxt : ptr_q;
    can_grant = bus.en & pick_any;
    credit_ld = WW'(weight_field(XARB_WBUS'(bus.weight), 32'(pick_id), WW));
    if (credit_ld == '0) credit_ld = WW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
      inpkt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_grant) begin
            state_q  <= BUSY;
            gnt_q    <= pick_win;
            gnt_id_q <= pick_id;
            credit_q <= credit_ld;
            inpkt_q  <= 1'b0;
          end
        end
        BUSY: begin
          if (xfer_c && !cur_last) inpkt_q <= 1'b1;
          if (tend) begin
            inpkt_q  <= 1'b0;
            credit_q <= credit_q - 1'b1;
          end
          if (rel) begin
            ptr_q <= ptr_nxt;
            if (can_grant) begin
              gnt_q    <= pick_win;
              gnt_id_q <= pick_id;
              credit_q <= credit_ld;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= '0;
              gnt_id_q <= '0;
              credit_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = (state_q == BUSY);
  assign bus.xfer    = xfer_c;

  a_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt_q));
  a_vld:    assert property (@(posedge clk) disable iff (!rstn) bus.gnt_vld == (|gnt_q));
  a_lock:   assert property (@(posedge clk) disable iff (!rstn)
                             (inpkt_q && !tend) |=> $stable(gnt_q));
  a_newreq: assert property (@(posedge clk) disable iff (!rstn)
                             (gnt_q & ~$past(gnt_q) & ~$past(bus.req)) == '0);
  a_proto:  assert property (@(posedge clk) disable iff (!rstn)
                             inpkt_q |-> cur_req);
endmodule

// File: tb/tb_xarb_wrr_lock.sv
// Scoreboard bench: directed scenarios plus random traffic against a spec-level model.
module tb_xarb_wrr_lock;
  localparam int unsigned N = 4, WW = 4, WB = N * WW;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xarb_wrr_lock_if #(.N(N), .WW(WW)) bus ();
  xarb_wrr_lock #(.N(N), .WW(WW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    logic         vld;
    logic         xfer;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;

  // model state: owner=-1 means no grant
  int owner = -1, cred = 0, ptr = 0;
  bit inpkt = 0;

  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int quantum(input logic [WB-1:0] w, input int i);
    logic [WB-1:0] s;
    int v;
    s = w >> (i * WW);
    v = int'(s[WW-1:0]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [WB-1:0] wpack(input int w0, w1, w2, w3);
    return {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
  endfunction

  task automatic step(input logic r_n, input logic e, input logic [N-1:0] rq,
                      input logic [N-1:0] ls, input logic [WB-1:0] w, input logic rd);
    exp_t x;
    bit xf, tend, rel;
    @(negedge clk);
    rstn = r_n; bus.en = e; bus.req = rq; bus.last = ls; bus.weight = w; bus.ready = rd;
    #1;
    if (!r_n) begin owner = -1; cred = 0; ptr = 0; inpkt = 0; end
    xf     = (owner >= 0) && rq[owner] && rd;
    x.gnt  = (owner >= 0) ? N'(1 << owner) : '0;
    x.id   = (owner >= 0) ? owner : 0;
    x.vld  = (owner >= 0);
    x.xfer = xf;
    q.push_back(x);
    if (r_n) begin
      if (owner < 0) begin
        if (e && rq != 0) begin
          owner = pick(ptr, rq); cred = quantum(w, owner); inpkt = 0;
        end
      end else begin
        tend = xf && ls[owner];
        rel  = (tend && cred == 1) || (!inpkt && !xf && (!rq[owner] || !e));
        if (xf && !ls[owner]) inpkt = 1;
        if (tend) begin inpkt = 0; cred = cred - 1; end
        if (rel) begin
          ptr = (owner + 1) % N;
          if (e && rq != 0) begin
            owner = pick(ptr, rq); cred = quantum(w, owner);
          end else owner = -1;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (bus.gnt !== e.gnt || bus.gnt_vld !== e.vld || bus.xfer !== e.xfer ||
          (e.vld && int'(bus.gnt_id) != e.id)) begin
        bad++;
        $display("FAIL grant @%0d: got gnt=%b id=%0d vld=%b xfer=%b, want gnt=%b id=%0d vld=%b xfer=%b",
                 cyc, bus.gnt, bus.gnt_id, bus.gnt_vld, bus.xfer, e.gnt, e.id, e.vld, e.xfer);
      end
    end
  end

  initial begin
    logic [WB-1:0] w1, w;
    logic [N-1:0] rq, ls;
    rstn = 1'b0; bus.en = 1'b0; bus.req = '0; bus.last = '0; bus.weight = '0; bus.ready = 1'b0;
    w1 = wpack(1, 1, 1, 1);

    // 1: reset while mid-packet, then a fresh grant
    do_reset();
    step(1, 1, 4'b0001, 4'b0000, w1, 1);
    step(1, 1, 4'b0001, 4'b0000, w1, 1);
    step(1, 1, 4'b0001, 4'b0000, w1, 1);
    step(0, 1, 4'b0001, 4'b0000, w1, 1);
    step(0, 1, 4'b0001, 4'b0000, w1, 1);
    step(1, 1, 4'b0001, 4'b0001, w1, 1);
    step(1, 1, 4'b0001, 4'b0001, w1, 1);
    step(1, 1, 4'b0000, 4'b0000, w1, 1);
    step(1, 1, 4'b0000, 4'b0000, w1, 1);

    // 2: plain round-robin
    do_reset();
    repeat (6) step(1, 1, 4'b1111, 4'b1111, w1, 1);
    step(1, 1, 4'b0000, 4'b0000, w1, 1);

    // 3: weighting, req0 quantum 3
    do_reset();
    repeat (10) step(1, 1, 4'b0011, 4'b1111, wpack(3, 1, 1, 1), 1);
    step(1, 1, 4'b0000, 4'b0000, w1, 1);

    // 4: packet lock with ready toggling
    do_reset();
    step(1, 1, 4'b1111, 4'b0000, w1, 1);
    step(1, 1, 4'b1111, 4'b0000, w1, 1);
    step(1, 1, 4'b1111, 4'b0000, w1, 0);
    step(1, 1, 4'b1111, 4'b0000, w1, 1);
    step(1, 1, 4'b1111, 4'b0000, w1, 1);
    step(1, 1, 4'b1111, 4'b0000, w1, 0);
    step(1, 1, 4'b1111, 4'b0001, w1, 1);
    repeat (4) step(1, 1, 4'b1110, 4'b1110, w1, 1);
    step(1, 1, 4'b0000, 4'b0000, w1, 1);

    // 5a: winner goes idle between transactions
    do_reset();
    w = wpack(5, 1, 1, 1);
    step(1, 1, 4'b0001, 4'b0001, w, 1);
    step(1, 1, 4'b0001, 4'b0001, w, 1);
    step(1, 1, 4'b0000, 4'b0000, w, 1);
    step(1, 1, 4'b0101, 4'b0100, w, 1);
    step(1, 1, 4'b0101, 4'b0100, w, 1);
    step(1, 1, 4'b0000, 4'b0000, w, 1);
    step(1, 1, 4'b0000, 4'b0000, w, 1);
    // 5b: en dropped mid-packet
    do_reset();
    step(1, 1, 4'b0010, 4'b0000, w1, 1);
    step(1, 1, 4'b0010, 4'b0000, w1, 1);
    step(1, 0, 4'b0010, 4'b0000, w1, 1);
    step(1, 0, 4'b0010, 4'b0010, w1, 1);
    step(1, 0, 4'b0000, 4'b0000, w1, 1);
    step(1, 0, 4'b0011, 4'b0000, w1, 1);
    step(1, 1, 4'b0000, 4'b0000, w1, 1);

    // 6: zero weight at ptr=3, then wrap to 0
    do_reset();
    w = wpack(1, 1, 1, 0);
    step(1, 1, 4'b0100, 4'b0100, w, 1);
    repeat (5) step(1, 1, 4'b1001, 4'b1001, w, 1);
    step(1, 1, 4'b0000, 4'b0000, w, 1);

    // random traffic
    do_reset();
    w = WB'($urandom);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(19) == 0) w = WB'($urandom);
      rq = N'($urandom);
      ls = N'($urandom);
      if (inpkt && owner >= 0) rq[owner] = 1'b1;
      step(($urandom_range(99) == 0) ? 1'b0 : 1'b1, ($urandom_range(7) != 0),
           rq, ls, w, ($urandom_range(3) != 0));
    end

    repeat (3) @(negedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xarb_wrr_lock.md
Name: xarb_wrr_lock

Overview:
- Weighted round-robin arbiter with packet lock; successor to the single-cycle round-robin arbiter.
- Grants one of N requesters and holds the grant for a whole multi-beat transaction.
- Lets a winner keep the grant for up to `weight[i]` back-to-back transactions before rotating.
- Sits in front of a shared target port in the switch fabric; drives the mux select and the upstream ready steering.

Parameters:
- N, 4, number of requesters (N >= 2).
- WW, 4, width of each per-requester weight field.
- IW, $clog2(N), width of gnt_id (derived, not overridable).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- en  in  1  arbitration enable; 0 blocks new grants and grant continuation.
- req  in  N  per-requester request; held high while a beat is offered.
- last  in  N  per-requester end-of-transaction flag, qualified by req.
- weight  in  N*WW  per-requester quantum in transactions, field i = weight[i*WW +: WW]; 0 is treated as 1.
- ready  in  1  downstream accepts the current beat.
- gnt  out  N  registered one-hot grant.
- gnt_id  out  IW  binary index of the granted requester; valid when gnt_vld=1.
- gnt_vld  out  1  a grant is active (state BUSY).
- xfer  out  1  beat accepted this cycle = gnt_vld & req[gnt_id] & ready.

Behaviour:
- Reset: asynchronous, active-low on rstn; clock clk.
  - All outputs 0.
  - State IDLE; ptr=0; credit=0; inpkt=0.
- State IDLE, en=1 and |req:
  - Winner W = first set req bit at or after ptr, wrapping modulo N.
  - Next cycle: state BUSY, gnt=onehot(W), gnt_id=W.
  - credit = max(weight[W],1), sampled at grant time only.
  - Request-to-grant latency is 1 cycle.
- IDLE with en=0 or req=0: stay IDLE, gnt=0.
- BUSY beat accounting:
  - A beat is accepted when xfer=1.
  - If xfer & ~last[W]: inpkt<=1 (locked mid-transaction).
  - If xfer & last[W]: transaction end; inpkt<=0; credit<=credit-1.
- BUSY release conditions, evaluated each cycle; any one true means release:
  - (a) transaction end with credit==1 (quantum exhausted);
  - (b) inpkt==0, no xfer this cycle, and req[W]==0 (winner idle between transactions);
  - (c) inpkt==0, no xfer this cycle, and en==0.
- While inpkt==1, the grant never changes, regardless of en, req, or the other requesters.
- On release:
  - ptr <= (W+1) mod N.
  - If en and |req, re-arbitrate in the same cycle from the new ptr, using the current req (W is lowest priority and wins only if it is the sole requester).
  - New gnt, gnt_id and credit take effect next cycle: zero-bubble handoff.
  - Otherwise go to IDLE.
- Transaction end with credit>1 and en=1: stay BUSY on W without rotating, even if other requesters are waiting.
- Single-beat transaction: req & last in the same beat; handled as an end with no inpkt set.
- req[W] dropping mid-packet (inpkt=1): a protocol violation, flagged by assertion; RTL holds the grant.
- weight changes while BUSY have no effect until the next grant.
- Non-synthesis assertions:
  - gnt is one-hot0;
  - gnt_vld == |gnt;
  - gnt does not change while inpkt=1;
  - a newly set gnt bit implies that req bit was high the previous cycle.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BUSY};
  - a weight-field extraction function;
  - an onehot-to-index function reused by other arbiters.
- One sub-module, xarb_rr_pick: combinational, takes req and ptr, returns the one-hot winner and its index. It is built as masked/unmasked first-one selection with fallback.
- The FSM, credit counter, ptr and inpkt logic live in the top.

Test Plan (N=4, WW=4, ready=1 unless stated):
1. Reset mid-transaction: assert rstn=0 while BUSY with inpkt=1 -> gnt=0, gnt_vld=0 immediately; after release, req=0001 grants 0001 one cycle later.
2. Plain round-robin: weights all 1, req=1111, every beat last=1 -> gnt sequence 0001,0010,0100,1000,0001, one grant per cycle with no bubbles.
3. Weighting: weight={1,1,1,3} (req0 weight 3), req=0011, single-beat transactions -> gnt 0001 for 3 cycles, then 0010 for 1, then 0001 for 3.
4. Packet lock: req0 sends a 4-beat packet with ready toggling 1,0,1,1,0,1 while req=1110 held -> gnt stays 0001 until the 4th xfer; the 0010 grant follows on the next cycle.
5. Idle release and enable: req0 granted with weight 5 drops req after one transaction -> release; ptr=1, and next winner 0100 is picked when req=0101. Separately, en=0 mid-packet -> packet completes, then IDLE with gnt=0.
6. Weight 0 and wrap: weight[3]=0, ptr=3, req=1001 -> gnt 1000 for exactly 1 transaction, then wraps to 0001.
